// File: rtl/pipe_pkg.sv
// Shared pipeline constants: datapath widths, ALU function codes and forwarding selects.
`default_nettype none

package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_XNOR = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b1100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

endpackage

`default_nettype wire

// File: rtl/fwd_unit.sv
// Forwarding select for one EX source register; EX/MEM beats MEM/WB and r0 never matches.
`default_nettype none

module fwd_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW = pipe_pkg::REG_AW
) (
  input  logic              src_valid,
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_reg_write,
  output logic [1:0]        sel
);

  logic w_src_nonzero;
  logic w_exmem_hit;
  logic w_memwb_hit;

  assign w_src_nonzero = (src != '0);
  assign w_exmem_hit   = src_valid && w_src_nonzero && exmem_reg_write && (exmem_rd == src);
  assign w_memwb_hit   = src_valid && w_src_nonzero && memwb_reg_write && (memwb_rd == src);

  always_comb begin
    sel = FWD_NONE;
    if (w_exmem_hit) begin
      sel = FWD_EXMEM;
    end else if (w_memwb_hit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with ID-side write-back bypass, EX/MEM and MEM/WB operand
// forwarding into the ALU, and load-use hazard detection with bubble insertion.
`default_nettype none

module ex_operand_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int REG_AW = pipe_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic [3:0]        id_alu_func,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              flush,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_reg_write,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              hazard_stall,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [3:0]        alu_func,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write
);

  logic              r_valid;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [REG_AW-1:0] r_rd;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [DATA_W-1:0] r_rs1_data;
  logic [DATA_W-1:0] r_rs2_data;
  logic [DATA_W-1:0] r_imm;
  logic              r_use_imm;
  logic [3:0]        r_func;

  logic              w_load_use;
  logic              w_rs2_needed;
  logic              w_bubble;
  logic [DATA_W-1:0] w_id_rs1_val;
  logic [DATA_W-1:0] w_id_rs2_val;
  logic [1:0]        w_sel_rs1;
  logic [1:0]        w_sel_rs2;
  logic [DATA_W-1:0] w_fwd_rs1;
  logic [DATA_W-1:0] w_fwd_rs2;

  // rs2 only matters to a load-use check when it feeds the ALU or is store data.
  assign w_rs2_needed = !id_use_imm || id_mem_write;
  assign w_load_use   = r_valid && r_mem_read && (r_rd != '0) && id_valid &&
                        ((r_rd == id_rs1) || ((r_rd == id_rs2) && w_rs2_needed));
  assign hazard_stall = w_load_use && !rst;

  assign w_bubble = flush || w_load_use || !id_valid;

  // A register written back this cycle is not yet visible in the register file read.
  always_comb begin
    w_id_rs1_val = id_rs1_data;
    w_id_rs2_val = id_rs2_data;
    if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rs1)) begin
      w_id_rs1_val = memwb_result;
    end
    if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rs2)) begin
      w_id_rs2_val = memwb_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_use_imm   <= 1'b0;
      r_func      <= ALU_AND;
    end else begin
      r_valid     <= 1'b1;
      r_reg_write <= id_reg_write;
      r_mem_read  <= id_mem_read;
      r_mem_write <= id_mem_write;
      r_rd        <= id_rd;
      r_rs1       <= id_rs1;
      r_rs2       <= id_rs2;
      r_rs1_data  <= w_id_rs1_val;
      r_rs2_data  <= w_id_rs2_val;
      r_imm       <= id_imm;
      r_use_imm   <= id_use_imm;
      r_func      <= id_alu_func;
    end
  end

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_rs1 (
    .src_valid       (r_valid),
    .src             (r_rs1),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .sel             (w_sel_rs1)
  );

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_rs2 (
    .src_valid       (r_valid),
    .src             (r_rs2),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .sel             (w_sel_rs2)
  );

  always_comb begin
    case (w_sel_rs1)
      FWD_EXMEM: w_fwd_rs1 = exmem_result;
      FWD_MEMWB: w_fwd_rs1 = memwb_result;
      default:   w_fwd_rs1 = r_rs1_data;
    endcase
    case (w_sel_rs2)
      FWD_EXMEM: w_fwd_rs2 = exmem_result;
      FWD_MEMWB: w_fwd_rs2 = memwb_result;
      default:   w_fwd_rs2 = r_rs2_data;
    endcase
  end

  assign alu_in1       = w_fwd_rs1;
  assign alu_in2       = r_use_imm ? r_imm : w_fwd_rs2;
  assign alu_func      = r_func;
  assign ex_store_data = w_fwd_rs2;
  assign ex_rd         = r_rd;
  assign ex_valid      = r_valid;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;

endmodule

`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
// Directed scoreboard bench for ex_operand_stage: expected EX outputs are queued with each step.
`default_nettype none

module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_use_imm;
  logic [3:0]  id_alu_func;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        flush;
  logic [4:0]  exmem_rd;
  logic        exmem_reg_write;
  logic [31:0] exmem_result;
  logic [4:0]  memwb_rd;
  logic        memwb_reg_write;
  logic [31:0] memwb_result;
  logic        hazard_stall;
  logic [31:0] alu_in1, alu_in2, ex_store_data;
  logic [3:0]  alu_func;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] sd;
    logic [3:0]  func;
    logic [4:0]  rd;
    logic        v, rw, mr, mw, st;
  } exp_t;

  exp_t  expq[$];
  string tagq[$];

  ex_operand_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_alu_func(id_alu_func),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .flush(flush),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .hazard_stall(hazard_stall), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_func(alu_func),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] in1, input logic [31:0] in2,
                      input logic [31:0] sd, input logic [3:0] func, input logic [4:0] rd,
                      input logic v, input logic rw, input logic mr, input logic mw,
                      input logic st);
    exp_t e;
    e.in1 = in1; e.in2 = in2; e.sd = sd; e.func = func; e.rd = rd;
    e.v = v; e.rw = rw; e.mr = mr; e.mw = mw; e.st = st;
    expq.push_back(e);
    tagq.push_back(tag);
  endtask

  task automatic cmp(input string tag, input string fld, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    end
  endtask

  task automatic check();
    exp_t  e;
    string t;
    if (expq.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = expq.pop_front();
    t = tagq.pop_front();
    cmp(t, "alu_in1",       alu_in1,       e.in1);
    cmp(t, "alu_in2",       alu_in2,       e.in2);
    cmp(t, "ex_store_data", ex_store_data, e.sd);
    cmp(t, "alu_func",      {28'd0, alu_func}, {28'd0, e.func});
    cmp(t, "ex_rd",         {27'd0, ex_rd},    {27'd0, e.rd});
    cmp(t, "ex_valid",      {31'd0, ex_valid},     {31'd0, e.v});
    cmp(t, "ex_reg_write",  {31'd0, ex_reg_write}, {31'd0, e.rw});
    cmp(t, "ex_mem_read",   {31'd0, ex_mem_read},  {31'd0, e.mr});
    cmp(t, "ex_mem_write",  {31'd0, ex_mem_write}, {31'd0, e.mw});
    cmp(t, "hazard_stall",  {31'd0, hazard_stall}, {31'd0, e.st});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_use_imm = 0;
    id_alu_func = 4'b0000; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
  endtask

  task automatic fwd_idle();
    exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
    memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0;
  endtask

  task automatic id_set(input logic [4:0] rs1, input logic [31:0] d1, input logic [4:0] rs2,
                        input logic [31:0] d2, input logic [4:0] rd, input logic [3:0] func,
                        input logic use_imm, input logic [31:0] imm, input logic rw,
                        input logic mr, input logic mw);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_use_imm = use_imm;
    id_alu_func = func; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  initial begin
    rst = 1; flush = 0;
    id_idle();
    fwd_idle();
    tick();
    tick();
    push("reset", 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    check();
    rst = 0;

    // Plain capture of an ADD.
    id_set(5'd1, 32'd5, 5'd2, 32'd11, 5'd7, 4'b0100, 0, 0, 1, 0, 0);
    push("capture", 32'd5, 32'd11, 32'd11, 4'b0100, 5'd7, 1, 1, 0, 0, 0);
    tick();
    check();

    // EX rs1=3 with both EX/MEM and MEM/WB targeting r3.
    id_set(5'd3, 32'hAA, 5'd0, 32'd0, 5'd8, 4'b0001, 0, 0, 1, 0, 0);
    tick();
    exmem_rd = 5'd3; exmem_reg_write = 1; exmem_result = 32'h10;
    memwb_rd = 5'd3; memwb_reg_write = 1; memwb_result = 32'h20;
    push("fwd_exmem", 32'h10, 32'd0, 32'd0, 4'b0001, 5'd8, 1, 1, 0, 0, 0);
    #1 check();
    exmem_reg_write = 0;
    push("fwd_memwb", 32'h20, 32'd0, 32'd0, 4'b0001, 5'd8, 1, 1, 0, 0, 0);
    #1 check();

    // r0 is never forwarded.
    fwd_idle();
    id_set(5'd0, 32'd0, 5'd5, 32'd3, 5'd9, 4'b0010, 0, 0, 1, 0, 0);
    tick();
    exmem_rd = 5'd0; exmem_reg_write = 1; exmem_result = 32'h55;
    memwb_rd = 5'd0; memwb_reg_write = 1; memwb_result = 32'h66;
    push("zero_reg", 32'd0, 32'd3, 32'd3, 4'b0010, 5'd9, 1, 1, 0, 0, 0);
    #1 check();

    // Load to r4 followed by a dependent SUB on rs2.
    fwd_idle();
    id_set(5'd1, 32'h100, 5'd0, 32'd0, 5'd4, 4'b0100, 1, 32'd4, 1, 1, 0);
    tick();
    id_set(5'd2, 32'd50, 5'd4, 32'hDEAD, 5'd10, 4'b1100, 0, 0, 1, 0, 0);
    push("load_use_stall", 32'h100, 32'd4, 32'd0, 4'b0100, 5'd4, 1, 1, 1, 0, 1);
    #1 check();
    push("load_use_bubble", 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    tick();
    check();
    tick();
    exmem_rd = 5'd4; exmem_reg_write = 1; exmem_result = 32'h1234;
    push("load_use_sub", 32'd50, 32'h1234, 32'h1234, 4'b1100, 5'd10, 1, 1, 0, 0, 0);
    #1 check();

    // Immediate selects In2 while store data keeps the forwarded rs2.
    fwd_idle();
    id_set(5'd1, 32'd2, 5'd2, 32'd9, 5'd0, 4'b0100, 1, 32'hFFFF_FFFA, 0, 0, 1);
    tick();
    memwb_rd = 5'd2; memwb_reg_write = 1; memwb_result = 32'd7;
    push("imm_store", 32'd2, 32'hFFFF_FFFA, 32'd7, 4'b0100, 5'd0, 1, 0, 0, 1, 0);
    #1 check();

    // id_valid low yields a bubble even with junk ID fields.
    fwd_idle();
    id_set(5'd7, 32'h77, 5'd8, 32'h88, 5'd12, 4'b0011, 0, 32'h5, 1, 0, 1);
    id_valid = 0;
    tick();
    push("id_invalid", 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    check();

    // Flush together with a load-use hazard.
    id_set(5'd3, 32'h40, 5'd0, 32'd0, 5'd5, 4'b0100, 1, 32'd0, 1, 1, 0);
    tick();
    id_set(5'd5, 32'd1, 5'd0, 32'd0, 5'd6, 4'b0001, 0, 0, 1, 0, 0);
    flush = 1;
    push("flush_hazard", 32'h40, 32'd0, 32'd0, 4'b0100, 5'd5, 1, 1, 1, 0, 1);
    #1 check();
    tick();
    flush = 0;
    push("flush_bubble", 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    #1 check();

    // Reset while a stall is pending.
    id_set(5'd3, 32'h40, 5'd0, 32'd0, 5'd5, 4'b0100, 1, 32'd0, 1, 1, 0);
    tick();
    id_set(5'd5, 32'd1, 5'd0, 32'd0, 5'd6, 4'b0001, 0, 0, 1, 0, 0);
    rst = 1;
    push("rst_during", 32'h40, 32'd0, 32'd0, 4'b0100, 5'd5, 1, 1, 1, 0, 0);
    #1 check();
    tick();
    push("rst_after", 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    check();
    rst = 0;

    // Write-back in the same cycle as the register file read.
    id_set(5'd6, 32'h1, 5'd0, 32'd0, 5'd11, 4'b0000, 0, 0, 1, 0, 0);
    memwb_rd = 5'd6; memwb_reg_write = 1; memwb_result = 32'h99;
    tick();
    fwd_idle();
    id_idle();
    push("id_bypass", 32'h99, 32'd0, 32'd0, 4'b0000, 5'd11, 1, 1, 0, 0, 0);
    #1 check();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
